loop_gain_scheduler: RTL
========================

# loop_gain_scheduler

Gain-scheduling and lock-detect controller for the ADPLL loop filter. It watches the signed phase/frequency error and sequences the loop through acquisition, tracking and locked states. In each state it drives the proportional and integral gain codes consumed by a dynamic-gain LoopFilter instance. It also produces lock status and a filter-clear strobe, and sits between the phase detector output and the LoopFilter.

## Interface
- ERROR_WIDTH, 8, width of signed error input
- KP_WIDTH, 5, width of proportional gain code
- KI_WIDTH, 8, width of integral gain code
- KP_ACQ / KI_ACQ, 5'b01000 / 8'b00010000, gains in ACQUIRE
- KP_TRK / KI_TRK, 5'b00010 / 8'b00000010, gains in TRACK and LOCKED
- ACQ_TOL, 8, |error| threshold to leave ACQUIRE
- ACQ_COUNT, 4, consecutive in-tolerance cycles to leave ACQUIRE
- LOCK_TOL, 2, |error| threshold for lock
- LOCK_COUNT, 8, consecutive cycles to declare lock
- UNLOCK_TOL, 16, |error| threshold for loss of lock
- UNLOCK_COUNT, 3, consecutive cycles to declare loss of lock
- ACQ_TIMEOUT, 64, ACQUIRE cycle budget (timeout feature only)
- MAX_RETRY, 2, acquisition restarts before FAIL (timeout feature only)

Ports:
- gen_clk_i  in  1  loop clock; all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- enable_i  in  1  loop run request
- error_i  in  ERROR_WIDTH  signed error sample, valid every cycle
- kp_o  out  KP_WIDTH  proportional gain code to loop filter
- ki_o  out  KI_WIDTH  integral gain code to loop filter
- filter_clear_o  out  1  clears loop filter integrator when high
- lock_o  out  1  high only in LOCKED
- fail_o  out  1  high only in FAIL
- state_o  out  3  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3, FAIL=4

## Operation
- Magnitude: mag = |error_i|, computed in ERROR_WIDTH bits. The most negative input saturates to 2^(ERROR_WIDTH-1)-1. All threshold comparisons are unsigned and inclusive (mag <= TOL is in tolerance; mag > TOL is out).
- One qualification counter, sized for the largest COUNT parameter. It is cleared on every state change and on any non-qualifying sample.
- IDLE:
  - kp_o=0, ki_o=0, filter_clear_o=1.
  - enable_i=1 moves to ACQUIRE.
- ACQUIRE:
  - KP_ACQ/KI_ACQ, filter_clear_o=0.
  - ACQ_COUNT consecutive samples with mag<=ACQ_TOL move to TRACK.
- TRACK:
  - KP_TRK/KI_TRK.
  - LOCK_COUNT consecutive samples with mag<=LOCK_TOL move to LOCKED.
  - Any single sample with mag>UNLOCK_TOL moves to ACQUIRE.
- LOCKED:
  - KP_TRK/KI_TRK, lock_o=1.
  - UNLOCK_COUNT consecutive samples with mag>UNLOCK_TOL move to ACQUIRE.
  - Samples at or below UNLOCK_TOL clear the counter.
- FAIL:
  - kp_o=0, ki_o=0, filter_clear_o=1, fail_o=1.
  - Exits only when enable_i=0, which moves to IDLE.
- enable_i=0 in any state moves to IDLE on the next edge. This has priority over every other transition.
- Simultaneous qualifying threshold and enable_i drop: IDLE wins.

## Timing
- All outputs are registered and decoded from the registered state; there is no combinational input-to-output path.
- Reset (reset_n_i=0 at an edge) gives:
  - state IDLE; kp_o=0, ki_o=0; filter_clear_o=1; lock_o=0, fail_o=0; state_o=0.
  - Counters and the retry count cleared.
  - Reset mid-operation takes effect at that edge regardless of state.
- Latency: the edge that samples the Nth consecutive qualifying error_i is the edge that updates the state. New gains and flags are visible immediately after that edge.
- enable_i rising in IDLE: ACQUIRE, with filter_clear_o low, one edge later.
- Gains change only on state transitions and are stable for the whole state.

## Configuration
- Macro LOOP_GAIN_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACQUIRE.
  - If ACQ_TIMEOUT cycles elapse without moving to TRACK, the block pulses filter_clear_o for exactly one cycle and re-enters ACQUIRE with counters cleared, then increments the retry count.
  - A timeout when the retry count equals MAX_RETRY moves to FAIL instead.
  - The retry count clears on entry to LOCKED or IDLE.
- Not defined:
  - ACQUIRE waits indefinitely.
  - FAIL is unreachable and fail_o is constant 0.
  - There is no timeout or retry logic.

## Test plan
All scenarios use default parameters.
- Reset and idle: hold reset_n_i=0 for 3 cycles with enable_i=1 -> state_o=0, kp_o=0, ki_o=0, filter_clear_o=1. Release reset -> state_o=1 one edge later.
- Acquisition to lock: error_i=+40 for 10 cycles, then +5 for 4 cycles -> TRACK after the 4th; then -2 for 8 cycles -> LOCKED and lock_o=1 after the 8th. Gains switch 8/16 -> 2/2 at the TRACK entry.
- Saturated magnitude: error_i=-128 in LOCKED for 3 cycles -> ACQUIRE after the 3rd. Pattern -128, -128, 0, -128 -> stays LOCKED.
- Counter break: in ACQUIRE apply +8, +8, +8, +9, then +8 x4 -> TRACK only after the final fourth +8.
- Enable priority: drop enable_i on the same edge as the 8th lock-qualifying sample -> IDLE, and lock_o never asserts.
- Timeout (macro defined): hold error_i=+100 in ACQUIRE -> filter_clear_o one-cycle pulse at cycles 64 and 128, FAIL at 192 with fail_o=1. Drop enable_i -> IDLE.

Source files
------------

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler: ADPLL gain scheduling and lock detect; define LOOP_GAIN_SCHED_TIMEOUT_EN for acquisition timeout/retry/FAIL
module loop_gain_scheduler #(
    parameter int ERROR_WIDTH = 8,
    parameter int KP_WIDTH = 5,
    parameter int KI_WIDTH = 8,
    parameter logic [KP_WIDTH-1:0] KP_ACQ = 5'b01000,
    parameter logic [KI_WIDTH-1:0] KI_ACQ = 8'b00010000,
    parameter logic [KP_WIDTH-1:0] KP_TRK = 5'b00010,
    parameter logic [KI_WIDTH-1:0] KI_TRK = 8'b00000010,
    parameter int ACQ_TOL = 8,
    parameter int ACQ_COUNT = 4,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_COUNT = 8,
    parameter int UNLOCK_TOL = 16,
    parameter int UNLOCK_COUNT = 3,
    parameter int ACQ_TIMEOUT = 64,
    parameter int MAX_RETRY = 2
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    output logic [KP_WIDTH-1:0]    kp_o,
    output logic [KI_WIDTH-1:0]    ki_o,
    output logic                   filter_clear_o,
    output logic                   lock_o,
    output logic                   fail_o,
    output logic [2:0]             state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, ACQUIRE = 3'd1, TRACK = 3'd2, LOCKED = 3'd3, FAIL = 3'd4} state_t;
    localparam int CMAX = (ACQ_COUNT > LOCK_COUNT) ? ((ACQ_COUNT > UNLOCK_COUNT) ? ACQ_COUNT : UNLOCK_COUNT)
                                                   : ((LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [ERROR_WIDTH-1:0] A_TOL = ERROR_WIDTH'(ACQ_TOL);
    localparam logic [ERROR_WIDTH-1:0] L_TOL = ERROR_WIDTH'(LOCK_TOL);
    localparam logic [ERROR_WIDTH-1:0] U_TOL = ERROR_WIDTH'(UNLOCK_TOL);
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [ERROR_WIDTH-1:0] neg, mag;
    logic pulse;
    // two's complement negate; only the most negative value stays negative and is saturated
    assign neg = ~error_i + 1'b1;
    assign mag = !error_i[ERROR_WIDTH-1] ? error_i : neg[ERROR_WIDTH-1] ? {1'b0, {(ERROR_WIDTH-1){1'b1}}} : neg;
    assign state_o = state;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(ACQ_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [TW-1:0] tmr, tmr_n;
    logic [RW-1:0] retry, retry_n;
`endif
    always_comb begin
        nxt = state;
        cnt_n = '0;
        pulse = 1'b0;
        case (state)
            IDLE: nxt = ACQUIRE;
            ACQUIRE: if (mag <= A_TOL) begin
                if (cnt == CW'(ACQ_COUNT - 1)) nxt = TRACK;
                else cnt_n = cnt + 1'b1;
            end
            TRACK: if (mag > U_TOL) nxt = ACQUIRE;
                else if (mag <= L_TOL) begin
                    if (cnt == CW'(LOCK_COUNT - 1)) nxt = LOCKED;
                    else cnt_n = cnt + 1'b1;
                end
            LOCKED: if (mag > U_TOL) begin
                if (cnt == CW'(UNLOCK_COUNT - 1)) nxt = ACQUIRE;
                else cnt_n = cnt + 1'b1;
            end
            FAIL: nxt = FAIL;
            default: nxt = IDLE;
        endcase
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
        tmr_n = (state == ACQUIRE) ? tmr + 1'b1 : '0;
        retry_n = retry;
        if (enable_i && state == ACQUIRE && nxt == ACQUIRE && tmr == TW'(ACQ_TIMEOUT - 1)) begin
            tmr_n = '0;
            cnt_n = '0;
            if (retry == RW'(MAX_RETRY)) nxt = FAIL;
            else begin
                retry_n = retry + 1'b1;
                pulse = 1'b1;
            end
        end
`endif
        if (!enable_i) nxt = IDLE;
        if (nxt != state || !enable_i) cnt_n = '0;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
        if (nxt != state) tmr_n = '0;
        if (nxt == IDLE || nxt == LOCKED) retry_n = '0;
`endif
    end
    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            cnt <= '0;
            kp_o <= '0;
            ki_o <= '0;
            filter_clear_o <= 1'b1;
            lock_o <= 1'b0;
            fail_o <= 1'b0;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
            tmr <= '0;
            retry <= '0;
`endif
        end else begin
            state <= nxt;
            cnt <= cnt_n;
            kp_o <= (nxt == ACQUIRE) ? KP_ACQ : (nxt == TRACK || nxt == LOCKED) ? KP_TRK : '0;
            ki_o <= (nxt == ACQUIRE) ? KI_ACQ : (nxt == TRACK || nxt == LOCKED) ? KI_TRK : '0;
            filter_clear_o <= nxt == IDLE || nxt == FAIL || pulse;
            lock_o <= nxt == LOCKED;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
            fail_o <= nxt == FAIL;
            tmr <= tmr_n;
            retry <= retry_n;
`else
            fail_o <= 1'b0;
`endif
        end
    end
endmodule
